// File: rtl/arith_extend_pipe.sv
// Multi-lane extend/truncate/saturate converter feeding a valid/ready register pipeline.
// Per-lane overflow travels with each beat; a sticky copy accumulates on delivery.
package util_pkg;
   typedef struct packed {
      logic clk;
      logic rst_n;
   } Util_Control_T;
endpackage

module arith_extend_pipe #(
   parameter int IN_W   = 16,
   parameter int OUT_W  = 32,
   parameter int DEPTH  = 2,
   parameter int STAGES = 1
) (
   input  util_pkg::Util_Control_T  i_ctrl,
   input  logic [DEPTH*IN_W-1:0]    i_in,
   input  logic [DEPTH*2-1:0]       i_mode,
   input  logic                     i_in_valid,
   output logic                     o_in_ready,
   output logic [DEPTH*OUT_W-1:0]   o_out,
   output logic [DEPTH-1:0]         o_ovf,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [DEPTH-1:0]         o_ovf_sticky,
   input  logic                     i_ovf_clr
);

   localparam int EW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

   // EW is one bit wider than either side, so signed/unsigned views and all bounds fit.
   function automatic logic [OUT_W:0] f_convert(input logic [IN_W-1:0] x, input logic [1:0] m);
      logic signed [EW-1:0] v, hi_u, hi_s, lo_s, r;
      logic ovf;
      hi_u = '0;
      hi_u[OUT_W-1:0] = '1;
      hi_s = hi_u >>> 1;
      lo_s = ~hi_s;
      if (m[0]) v = $signed({{(EW-IN_W){x[IN_W-1]}}, x});
      else      v = $signed({{(EW-IN_W){1'b0}}, x});
      ovf = m[0] ? ((v > hi_s) || (v < lo_s)) : (v > hi_u);
      r = v;
      if (m[1] && ovf) r = m[0] ? (v[EW-1] ? lo_s : hi_s) : hi_u;
      return {ovf, r[OUT_W-1:0]};
   endfunction

   logic                   w_clk;
   logic                   w_rst_n;
   logic [DEPTH*OUT_W-1:0] w_conv_data;
   logic [DEPTH-1:0]       w_conv_ovf;
   logic [STAGES-1:0]      w_ld;
   logic [STAGES-1:0]      w_src_vld;
   logic [DEPTH*OUT_W-1:0] w_src_data [STAGES];
   logic [DEPTH-1:0]       w_src_ovf  [STAGES];
   logic                   w_deliver;

   logic [STAGES-1:0]      r_vld;
   logic [DEPTH*OUT_W-1:0] r_data [STAGES];
   logic [DEPTH-1:0]       r_ovf  [STAGES];
   logic [DEPTH-1:0]       r_sticky;

   assign w_clk   = i_ctrl.clk;
   assign w_rst_n = i_ctrl.rst_n;

   always_comb begin
      w_conv_data = '0;
      w_conv_ovf  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         {w_conv_ovf[i], w_conv_data[i*OUT_W +: OUT_W]} =
            f_convert(i_in[i*IN_W +: IN_W], i_mode[i*2 +: 2]);
      end
   end

   // A slice may load when the consumer is taking a beat or any slice at or after it is empty.
   always_comb begin
      w_ld = '0;
      for (int k = 0; k < STAGES; k++) begin
         w_ld[k] = i_out_ready;
         for (int j = k; j < STAGES; j++) begin
            if (!r_vld[j]) w_ld[k] = 1'b1;
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_src
      if (k == 0) begin : g_in
         assign w_src_vld[k]  = i_in_valid;
         assign w_src_data[k] = w_conv_data;
         assign w_src_ovf[k]  = w_conv_ovf;
      end else begin : g_prev
         assign w_src_vld[k]  = r_vld[k-1];
         assign w_src_data[k] = r_data[k-1];
         assign w_src_ovf[k]  = r_ovf[k-1];
      end
   end

   assign w_deliver = r_vld[STAGES-1] && i_out_ready;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_vld    <= '0;
         r_sticky <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k] <= '0;
            r_ovf[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_ld[k]) begin
               r_vld[k] <= w_src_vld[k];
               if (w_src_vld[k]) begin
                  r_data[k] <= w_src_data[k];
                  r_ovf[k]  <= w_src_ovf[k];
               end
            end
         end
         // A clear coinciding with a new overflow keeps the new overflow.
         r_sticky <= (i_ovf_clr ? '0 : r_sticky) | (w_deliver ? r_ovf[STAGES-1] : '0);
      end
   end

   assign o_in_ready   = w_ld[0];
   assign o_out        = r_data[STAGES-1];
   assign o_ovf        = r_ovf[STAGES-1];
   assign o_out_valid  = r_vld[STAGES-1];
   assign o_ovf_sticky = r_sticky;

endmodule

// File: tb/tb_arith_extend_pipe.sv
// Bench for arith_extend_pipe: three configurations (16->32 S1, 16->8 S3, 16->8 S2) sharing clock/reset.
module tb_arith_extend_pipe;

   typedef struct {
      logic [63:0] d;
      logic [1:0]  o;
   } exp_t;

   util_pkg::Util_Control_T ctrl;
   int n_checks = 0;
   int n_errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   logic [31:0] a_in, b_in, c_in;
   logic [3:0]  a_mode, b_mode, c_mode;
   logic        a_iv, a_ir, a_ov, a_or, a_clr;
   logic        b_iv, b_ir, b_ov, b_or, b_clr;
   logic        c_iv, c_ir, c_ov, c_or, c_clr;
   logic [63:0] a_out;
   logic [15:0] b_out, c_out;
   logic [1:0]  a_ovf, b_ovf, c_ovf, a_st, b_st, c_st;

   arith_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2), .STAGES(1)) u_a (
      .i_ctrl(ctrl), .i_in(a_in), .i_mode(a_mode), .i_in_valid(a_iv), .o_in_ready(a_ir),
      .o_out(a_out), .o_ovf(a_ovf), .o_out_valid(a_ov), .i_out_ready(a_or),
      .o_ovf_sticky(a_st), .i_ovf_clr(a_clr));
   arith_extend_pipe #(.IN_W(16), .OUT_W(8), .DEPTH(2), .STAGES(3)) u_b (
      .i_ctrl(ctrl), .i_in(b_in), .i_mode(b_mode), .i_in_valid(b_iv), .o_in_ready(b_ir),
      .o_out(b_out), .o_ovf(b_ovf), .o_out_valid(b_ov), .i_out_ready(b_or),
      .o_ovf_sticky(b_st), .i_ovf_clr(b_clr));
   arith_extend_pipe #(.IN_W(16), .OUT_W(8), .DEPTH(2), .STAGES(2)) u_c (
      .i_ctrl(ctrl), .i_in(c_in), .i_mode(c_mode), .i_in_valid(c_iv), .o_in_ready(c_ir),
      .o_out(c_out), .o_ovf(c_ovf), .o_out_valid(c_ov), .i_out_ready(c_or),
      .o_ovf_sticky(c_st), .i_ovf_clr(c_clr));

   always #5 ctrl.clk = ~ctrl.clk;

   // Reference conversion on 64-bit integers: returns {ovf, data[31:0]} for an ow-bit output.
   function automatic logic [32:0] model(input logic [15:0] x, input logic [1:0] m, input int ow);
      longint v, hu, hs, ls, r;
      logic ovf;
      hu = (longint'(1) << ow) - 1;
      hs = (longint'(1) << (ow - 1)) - 1;
      ls = -(longint'(1) << (ow - 1));
      if (m[0]) v = longint'($signed(x));
      else      v = longint'({48'd0, x});
      ovf = m[0] ? ((v > hs) || (v < ls)) : (v > hu);
      r = v;
      if (m[1] && ovf) r = m[0] ? ((v < 0) ? ls : hs) : hu;
      r = r & hu;
      return {ovf, r[31:0]};
   endfunction

   function automatic exp_t exp_pair8(input logic [31:0] x, input logic [3:0] m);
      logic [32:0] r0, r1;
      exp_t e;
      r0 = model(x[15:0], m[1:0], 8);
      r1 = model(x[31:16], m[3:2], 8);
      e.d = {48'd0, r1[7:0], r0[7:0]};
      e.o = {r1[32], r0[32]};
      return e;
   endfunction

   task automatic c_push(input logic [31:0] x, input logic [3:0] m, output bit ok);
      c_in = x; c_mode = m; c_iv = 1'b1; ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge ctrl.clk);
         if (c_ir) begin
            ok = 1'b1;
            qc.push_back(exp_pair8(x, m));
         end
         @(posedge ctrl.clk); #1;
      end
      c_iv = 1'b0;
   endtask

   task automatic c_wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge ctrl.clk);
         if (c_ov) ok = 1'b1;
         else begin @(posedge ctrl.clk); #1; end
      end
   endtask

   task automatic test_reset;
      ctrl.rst_n = 1'b0;
      {a_in, b_in, c_in} = '0; {a_mode, b_mode, c_mode} = '0;
      {a_iv, b_iv, c_iv, a_or, b_or, c_or, a_clr, b_clr, c_clr} = '0;
      repeat (3) @(posedge ctrl.clk); #1;
      n_checks++;
      if ({a_ov, b_ov, c_ov} !== 3'b000) begin
         n_errors++; $display("FAIL reset_valid: got %b expected 000", {a_ov, b_ov, c_ov});
      end
      n_checks++;
      if ({a_out, b_out, c_out} !== 96'd0) begin
         n_errors++; $display("FAIL reset_out: got %h expected 0", {a_out, b_out, c_out});
      end
      n_checks++;
      if ({a_ovf, b_ovf, c_ovf, a_st, b_st, c_st} !== 12'd0) begin
         n_errors++; $display("FAIL reset_ovf: got %h expected 0", {a_ovf, b_ovf, c_ovf, a_st, b_st, c_st});
      end
      @(negedge ctrl.clk); ctrl.rst_n = 1'b1;
      @(posedge ctrl.clk); #1;
      n_checks++;
      if ({a_ir, b_ir, c_ir} !== 3'b111) begin
         n_errors++; $display("FAIL reset_in_ready: got %b expected 111", {a_ir, b_ir, c_ir});
      end
   endtask

   task automatic test_extend;
      logic [32:0] r0, r1;
      exp_t e;
      a_or = 1'b1;
      for (int b = 0; b < 3; b++) begin
         a_iv = (b < 2);
         a_in = {16'h8000, 16'h8000};
         a_mode = (b == 0) ? 4'b0001 : 4'b1011;
         @(negedge ctrl.clk);
         n_checks++;
         if (a_ov !== (b != 0)) begin
            n_errors++; $display("FAIL ext_latency beat%0d: out_valid %b expected %b", b, a_ov, (b != 0));
         end
         if (a_ov) begin
            e = qa.pop_front();
            n_checks++;
            if ({a_ovf, a_out} !== {e.o, e.d}) begin
               n_errors++; $display("FAIL ext_model: got %h/%h expected %h/%h", a_ovf, a_out, e.o, e.d);
            end
            n_checks++;
            if ({a_ovf, a_out} !== {2'b00, 64'h00008000_FFFF8000}) begin
               n_errors++; $display("FAIL ext_const: got %h/%h expected 0/00008000ffff8000", a_ovf, a_out);
            end
         end
         if (a_iv && a_ir) begin
            r0 = model(a_in[15:0], a_mode[1:0], 32);
            r1 = model(a_in[31:16], a_mode[3:2], 32);
            qa.push_back('{d: {r1[31:0], r0[31:0]}, o: {r1[32], r0[32]}});
         end
         @(posedge ctrl.clk); #1;
      end
      a_iv = 1'b0;
      @(negedge ctrl.clk);
      n_checks++;
      if (a_ov !== 1'b0 || qa.size() != 0) begin
         n_errors++; $display("FAIL ext_drain: out_valid %b pending %0d expected 0/0", a_ov, qa.size());
      end
      @(posedge ctrl.clk); #1;
   endtask

   task automatic test_convert;
      logic [31:0] t_in [6];
      logic [3:0]  t_mode [6];
      logic [15:0] t_d [6];
      logic [1:0]  t_o [6];
      int sent = 0, got = 0;
      exp_t e;
      t_in   = '{32'h0123_0123, 32'h0123_0123, 32'hFF80_FF80, 32'h8000_00FF, 32'hFF7F_FF80, 32'h0080_007F};
      t_mode = '{4'b0100, 4'b1110, 4'b0111, 4'b1110, 4'b1100, 4'b1111};
      t_d    = '{16'h2323, 16'h7FFF, 16'h8080, 16'h80FF, 16'h8080, 16'h7F7F};
      t_o    = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b11, 2'b10};
      b_or = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         if (sent < 6) begin b_iv = 1'b1; b_in = t_in[sent]; b_mode = t_mode[sent]; end
         else b_iv = 1'b0;
         @(negedge ctrl.clk);
         if (b_ov && b_or) begin
            n_checks++;
            if (qb.size() == 0) begin
               n_errors++; $display("FAIL conv_extra: unexpected beat %h", b_out);
            end else begin
               e = qb.pop_front();
               if ({b_ovf, b_out} !== {e.o, e.d[15:0]}) begin
                  n_errors++; $display("FAIL conv_beat%0d: got %b/%h expected %b/%h", got, b_ovf, b_out, e.o, e.d[15:0]);
               end
            end
            got++;
         end
         if (b_iv && b_ir) begin
            qb.push_back('{d: {48'd0, t_d[sent]}, o: t_o[sent]});
            sent++;
         end
         @(posedge ctrl.clk); #1;
      end
      b_iv = 1'b0;
      n_checks++;
      if (got != 6) begin
         n_errors++; $display("FAIL conv_count: got %0d beats expected 6", got);
      end
   endtask

   task automatic test_back_to_back;
      int sent = 0, got = 0;
      bit prev_stall = 1'b0;
      logic [15:0] prev_out = '0;
      logic [1:0] prev_ovf = '0;
      logic exp_rdy;
      exp_t e;
      for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
         b_or = (cyc % 3 == 0);
         if (sent < 20) begin
            b_iv = 1'b1;
            b_in = {16'(16'hFFF0 + sent), 16'(sent)};
            b_mode = {~sent[1:0], sent[1:0]};
         end else b_iv = 1'b0;
         @(negedge ctrl.clk);
         exp_rdy = !((qb.size() == 3) && !b_or);
         n_checks++;
         if (b_ir !== exp_rdy) begin
            n_errors++; $display("FAIL b2b_ready cyc%0d: got %b expected %b", cyc, b_ir, exp_rdy);
         end
         if (prev_stall) begin
            n_checks++;
            if ({b_ov, b_ovf, b_out} !== {1'b1, prev_ovf, prev_out}) begin
               n_errors++; $display("FAIL b2b_hold cyc%0d: got %b/%b/%h expected 1/%b/%h", cyc, b_ov, b_ovf, b_out, prev_ovf, prev_out);
            end
         end
         if (b_ov && b_or) begin
            n_checks++;
            if (qb.size() == 0) begin
               n_errors++; $display("FAIL b2b_extra: unexpected beat %h", b_out);
            end else begin
               e = qb.pop_front();
               if ({b_ovf, b_out} !== {e.o, e.d[15:0]}) begin
                  n_errors++; $display("FAIL b2b_beat%0d: got %b/%h expected %b/%h", got, b_ovf, b_out, e.o, e.d[15:0]);
               end
            end
            got++;
         end
         prev_stall = b_ov && !b_or;
         prev_out = b_out;
         prev_ovf = b_ovf;
         if (b_iv && b_ir) begin
            qb.push_back(exp_pair8(b_in, b_mode));
            sent++;
         end
         @(posedge ctrl.clk); #1;
      end
      b_iv = 1'b0;
      b_or = 1'b0;
      n_checks++;
      if (got != 20 || qb.size() != 0) begin
         n_errors++; $display("FAIL b2b_count: delivered %0d pending %0d expected 20/0", got, qb.size());
      end
   endtask

   task automatic test_sticky;
      logic [31:0] x [3];
      logic [3:0]  m [3];
      logic        clr [3];
      logic [1:0]  st [3];
      bit ok;
      exp_t e;
      x   = '{32'h7FFF_0001, 32'h0001_0100, 32'h7FFF_0005};
      m   = '{4'b1100, 4'b0010, 4'b1101};
      clr = '{1'b0, 1'b0, 1'b1};
      st  = '{2'b10, 2'b01, 2'b10};
      c_or = 1'b0;
      for (int b = 0; b < 3; b++) begin
         c_push(x[b], m[b], ok);
         if (ok) c_wait_out(ok);
         n_checks++;
         if (!ok) begin
            n_errors++; $display("FAIL sticky_timeout beat%0d: got no beat expected one", b);
         end else begin
            e = qc.pop_front();
            if ({c_ovf, c_out} !== {e.o, e.d[15:0]}) begin
               n_errors++; $display("FAIL sticky_beat%0d: got %b/%h expected %b/%h", b, c_ovf, c_out, e.o, e.d[15:0]);
            end
         end
         c_or = 1'b1; c_clr = clr[b];
         @(posedge ctrl.clk); #1;
         c_or = 1'b0; c_clr = 1'b0;
         n_checks++;
         if (c_st !== st[b]) begin
            n_errors++; $display("FAIL sticky_after%0d: got %b expected %b", b, c_st, st[b]);
         end
         if (b == 0) begin
            c_clr = 1'b1;
            @(posedge ctrl.clk); #1;
            c_clr = 1'b0;
            n_checks++;
            if (c_st !== 2'b00) begin
               n_errors++; $display("FAIL sticky_clear: got %b expected 00", c_st);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      bit ok0, ok1;
      exp_t e;
      c_or = 1'b0;
      c_push(32'h1234_0042, 4'b0000, ok0);
      c_push(32'h7FFF_0043, 4'b1100, ok1);
      @(negedge ctrl.clk);
      n_checks++;
      if (!(ok0 && ok1) || c_ir !== 1'b0 || c_ov !== 1'b1) begin
         n_errors++; $display("FAIL rmid_full: accepted %b%b in_ready %b out_valid %b expected 11/0/1", ok0, ok1, c_ir, c_ov);
      end
      c_iv = 1'b1; c_in = 32'hDEAD_BEEF;
      @(posedge ctrl.clk); #3;
      c_iv = 1'b0;
      ctrl.rst_n = 1'b0;
      #1;
      n_checks++;
      if ({c_ov, c_ovf, c_out, c_st} !== 21'd0) begin
         n_errors++; $display("FAIL rmid_async: got %b/%b/%h/%b expected all 0", c_ov, c_ovf, c_out, c_st);
      end
      qc.delete();
      @(negedge ctrl.clk); #2;
      ctrl.rst_n = 1'b1;
      c_or = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge ctrl.clk);
         n_checks++;
         if (c_ov !== 1'b0) begin
            n_errors++; $display("FAIL rmid_stale cyc%0d: out_valid %b expected 0", i, c_ov);
         end
      end
      @(posedge ctrl.clk); #1;
      c_push(32'hFF80_0123, 4'b0111, ok0);
      n_checks++;
      if (!ok0 || c_ov !== 1'b0) begin
         n_errors++; $display("FAIL rmid_lat1: accepted %b out_valid %b expected 1/0", ok0, c_ov);
      end
      @(posedge ctrl.clk); #1;
      n_checks++;
      if (c_ov !== 1'b1 || qc.size() != 1) begin
         n_errors++; $display("FAIL rmid_lat2: out_valid %b pending %0d expected 1/1", c_ov, qc.size());
      end else begin
         e = qc.pop_front();
         n_checks++;
         if ({c_ovf, c_out} !== {e.o, e.d[15:0]}) begin
            n_errors++; $display("FAIL rmid_beat: got %b/%h expected %b/%h", c_ovf, c_out, e.o, e.d[15:0]);
         end
      end
      @(posedge ctrl.clk); #1;
      c_or = 1'b0;
   endtask

   initial begin
      ctrl.clk = 1'b0;
      ctrl.rst_n = 1'b0;
      test_reset();
      test_extend();
      test_convert();
      test_back_to_back();
      test_sticky();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
      $fatal(1);
   end

endmodule

// File: doc/arith_extend_pipe.md
Name: arith_extend_pipe

Overview:
Multi-lane width converter with per-lane mode select: zero/sign extension, truncation, or saturation from IN_W to OUT_W. Wraps the conversion in a STAGES-deep valid/ready register pipeline with full-throughput backpressure. Reports per-lane overflow, both per beat and as a sticky status. Sits between the decode/immediate path and the execute-stage operand muxes, replacing the bare per-cycle extend register.

Parameters:
IN_W, 16, input lane width (>=1)
OUT_W, 32, output lane width (>=1; may be less than IN_W)
DEPTH, 2, number of independent lanes per beat
STAGES, 1, pipeline register stages (>=1); latency in cycles

Ports:
ctrl  input  Util_Control_T bundle  carries the single clock (rising edge) and reset; reset is asynchronous and active-low
in  input  DEPTH*IN_W  packed lanes, lane i at bits [i*IN_W +: IN_W]
mode  input  DEPTH*2  per-lane mode, lane i at bits [i*2 +: 2]
in_valid  input  1  beat offered
in_ready  output  1  beat accepted when in_valid && in_ready
out  output  DEPTH*OUT_W  packed converted lanes
ovf  output  DEPTH  per-lane overflow for the beat on out
out_valid  output  1  out/ovf hold a valid beat
out_ready  input  1  consumer takes beat when out_valid && out_ready
ovf_sticky  output  DEPTH  per-lane OR of ovf over all delivered beats since clear
ovf_clr  input  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (asserted low, async): all stage valids 0, out = 0, ovf = 0, ovf_sticky = 0. in_ready reads 1 in the first cycle after reset release.
- Modes per lane:
  - 00 zero: unsigned interpretation; extend with 0 or truncate.
  - 01 sign: signed interpretation; extend with in[IN_W-1] or truncate.
  - 10 usat: unsigned saturate.
  - 11 ssat: signed saturate.
- OUT_W >= IN_W:
  - 00 and 10 zero-extend.
  - 01 and 11 sign-extend.
  - ovf always 0.
- OUT_W < IN_W:
  - 00/01 keep the low OUT_W bits.
  - 10 clamps to 2^OUT_W-1 when value > 2^OUT_W-1.
  - 11 clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - ovf=1 when the input value (unsigned for 00/10, signed for 01/11) is not representable in OUT_W, whether the lane truncated or clamped.
- Conversion is combinational at pipeline entry. Lanes are fully independent.
- Pipeline:
  - STAGES register slices, each holding data, ovf and valid.
  - Stage k loads when it is empty or its downstream slice is loading or draining.
  - in_ready = stage 0 can load. in_ready may depend combinationally on out_ready.
  - Latency is exactly STAGES cycles with out_ready held high.
  - Throughput is 1 beat/cycle with out_ready high. No beat is dropped or duplicated under any out_ready pattern.
- Out hold: while out_valid && !out_ready, out and ovf stay stable.
- Full pipeline with out_ready low: in_ready=0 and the input beat is not taken.
- Simultaneous push and pop on a full pipeline: both happen in the same cycle, and occupancy is unchanged.
- ovf_sticky:
  - Sets on the delivery cycle (out_valid && out_ready) for each lane whose ovf=1.
  - ovf_clr clears it.
  - Clear and set in the same cycle: set wins, so the new overflow is not lost.
- Reset mid-operation: all in-flight beats are discarded, with no output handshake for them.
- in/mode are sampled only on acceptance. Changes while in_ready=0 have no effect.

Test Plan:
- IN_W=16, OUT_W=32, STAGES=1: lane0=0x8000 mode 01, lane1=0x8000 mode 00 -> out lane0=0xFFFF8000, lane1=0x00008000, ovf=00, out_valid exactly 1 cycle after accept.
- IN_W=16, OUT_W=8: 0x0123 in modes 00/01/10/11 -> 0x23 ovf1 / 0x23 ovf1 / 0xFF ovf1 / 0x7F ovf1; 0xFF80 mode 11 -> 0x80 ovf0; 0xFF80 mode 01 -> 0x80 ovf0.
- STAGES=3, in_valid constant with incrementing data 0..19, out_ready toggling 1,0,0,1,... -> all 20 beats out in order, none lost or repeated, out stable during stalls, in_ready=0 only while full.
- STAGES=2, OUT_W=8: deliver ssat beat 0x7FFF (ovf) on lane1 -> ovf_sticky=10; pulse ovf_clr with no overflow in that cycle -> 00; pulse ovf_clr in the same cycle as another overflowing delivery -> stays 10.
- Assert reset (low) asynchronously mid-clock with 2 beats in flight -> out_valid, out, ovf and ovf_sticky are 0 immediately. After release, no stale beat appears and the next accepted beat emerges after STAGES cycles.
